// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_HALT
  } fetch_state_e;

  localparam logic [3:0]  OPC_HLT   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_RESET  = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch stage feeding IF/ID
// Optional FETCH_PERF_CNT_EN adds fetch_count_o (words delivered to IF/ID).
module fetch_unit
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         redirect_i,
  input  logic [15:0]  redirect_pc_i,
  fetch_unit_if.master imem,
  output logic [15:0]  ifid_instr_o,
  output logic [15:0]  ifid_pc_o,
  output logic         ifid_valid_o,
  output logic         halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]  fetch_count_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  hold_q, hold_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  ifid_pc_q, ifid_pc_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic         load;
  logic         have_word;
  logic [15:0]  word;
  logic [15:0]  pc_inc;

  assign pc_inc    = pc_q + 16'd1;
  assign word      = (state_q == S_HOLD) ? hold_q : imem.imem_rdata;
  assign have_word = (state_q == S_HOLD) || ((state_q == S_WAIT) && imem.imem_valid);

  // A redirect in the request cycle would leave a stale request in flight, so it suppresses it
  assign imem.imem_req  = (state_q == S_REQ) && !rst && !redirect_i;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    instr_d   = instr_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    load      = 1'b0;

    if (redirect_i) begin
      pc_d     = redirect_pc_i;
      hold_d   = NOP_INSTR;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      // An in-flight response still has to be swallowed unless it lands this very cycle
      if (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem.imem_valid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_REQ;
      end
    end else if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      hold_d  = NOP_INSTR;
      case (state_q)
        S_REQ:          state_d = S_WAIT;
        S_HOLD:         state_d = S_REQ;
        S_WAIT, S_DROP: if (imem.imem_valid) state_d = S_REQ;
        default:        state_d = state_q;
      endcase
    end else begin
      case (state_q)
        S_REQ:  state_d = S_WAIT;
        S_DROP: if (imem.imem_valid) state_d = S_REQ;
        S_WAIT, S_HOLD: begin
          if (have_word) begin
            if (stall_i) begin
              hold_d  = word;
              state_d = S_HOLD;
            end else begin
              load = 1'b1;
            end
          end
        end
        default: state_d = state_q;
      endcase

      if (load) begin
        instr_d   = word;
        ifid_pc_d = pc_inc;
        valid_d   = 1'b1;
        pc_d      = pc_inc;
        if (word[15:12] == OPC_HLT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end else if (!stall_i) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= PC_RESET;
      hold_q    <= NOP_INSTR;
      instr_q   <= NOP_INSTR;
      ifid_pc_q <= PC_RESET;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      instr_q   <= instr_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] count_q, count_d;

  assign count_d = load ? (count_q + 16'd1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign fetch_count_o = count_q;
`endif

  assign ifid_instr_o = instr_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_valid_o = valid_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table, hand sequences and randomized model check for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr, ifid_pc;
  logic        ifid_valid, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem         (imem),
    .ifid_instr_o (ifid_instr),
    .ifid_pc_o    (ifid_pc),
    .ifid_valid_o (ifid_valid),
    .halted_o     (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count_o(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, flush, redir;
    logic [15:0] rpc;
    logic        mv;
    logic [15:0] mrd;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_iv;
    logic [15:0] e_ii, e_ip;
    logic        e_halt;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: outstanding-request flags plus a one-word hold slot
  logic [15:0] m_pc, m_hold, m_ii, m_ip, m_cnt;
  logic        m_pend, m_drop, m_hold_v, m_iv, m_halted;
  logic [15:0] mem [256];

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic rd,
                              input logic [15:0] rpc, input logic mv, input logic [15:0] mrd,
                              input logic er, input logic [15:0] ea, input logic eiv,
                              input logic [15:0] eii, input logic [15:0] eip, input logic eh);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.redir = rd; v.rpc = rpc; v.mv = mv; v.mrd = mrd;
    v.e_req = er; v.e_addr = ea; v.e_iv = eiv; v.e_ii = eii; v.e_ip = eip; v.e_halt = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic rd,
                       input logic [15:0] rpc, input logic mv, input logic [15:0] mrd);
    rst = r; stall = s; flush = f; redirect = rd; redirect_pc = rpc;
    imem.imem_valid = mv; imem.imem_rdata = mrd;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    @(negedge clk);
    drive(v.rst, v.stall, v.flush, v.redir, v.rpc, v.mv, v.mrd);
    #1;
    check({tag, " req"}, 16'(imem.imem_req), 16'(v.e_req));
    if (v.e_req) check({tag, " addr"}, imem.imem_addr, v.e_addr);
    check({tag, " ifid_valid"}, 16'(ifid_valid), 16'(v.e_iv));
    check({tag, " ifid_instr"}, ifid_instr, v.e_ii);
    check({tag, " ifid_pc"}, ifid_pc, v.e_ip);
    check({tag, " halted"}, 16'(halted), 16'(v.e_halt));
  endtask

  task automatic model_step(input logic r, input logic rd, input logic [15:0] rpc, input logic f,
                            input logic s, input logic mv, input logic [15:0] mrd, input logic req);
    logic        arrived;
    logic [15:0] w;
    if (r) begin
      m_pc = 16'h0; m_pend = 1'b0; m_drop = 1'b0; m_hold_v = 1'b0; m_hold = 16'h0;
      m_ii = 16'h0; m_ip = 16'h0; m_iv = 1'b0; m_halted = 1'b0; m_cnt = 16'h0;
      return;
    end
    if (rd) begin
      m_pc = rpc; m_hold_v = 1'b0; m_iv = 1'b0; m_halted = 1'b0;
      if (m_pend && !mv) m_drop = 1'b1;
      else begin m_pend = 1'b0; m_drop = 1'b0; end
      return;
    end
    arrived = 1'b0;
    w = 16'h0;
    if (req) begin
      m_pend = 1'b1; m_drop = 1'b0;
    end else if (mv && m_pend) begin
      m_pend = 1'b0;
      if (m_drop) m_drop = 1'b0;
      else begin arrived = 1'b1; w = mrd; end
    end
    if (f) begin
      m_iv = 1'b0; m_ii = 16'h0; m_hold_v = 1'b0;
    end else if (s) begin
      if (arrived) begin m_hold = w; m_hold_v = 1'b1; end
    end else if (arrived || m_hold_v) begin
      if (!arrived) w = m_hold;
      m_ii = w; m_ip = m_pc + 16'd1; m_iv = 1'b1; m_pc = m_pc + 16'd1;
      m_cnt = m_cnt + 16'd1; m_hold_v = 1'b0;
      if (w[15:12] == 4'hF) m_halted = 1'b1;
    end else begin
      m_iv = 1'b0;
    end
  endtask

  initial begin
    logic        r_rst, r_redir, r_flush, r_stall, r_mv, e_req;
    logic [15:0] r_rpc, r_mrd, mem_addr;
    logic        mem_busy;
    int          mem_left;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (2) @(negedge clk);

    //        rst s f rd rpc     mv mrd      req addr    iv ii       ip       h
    tbl.push_back(mk(1,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h1234, 0,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0001,1,16'h1234,16'h0001,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,1,16'hA5A5, 0,16'h0000,0,16'h1234,16'h0001,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h1234,16'h0001,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h1234,16'h0001,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h1234,16'h0001,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0002,1,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,1,16'h0005,1,16'h1111, 0,16'h0000,0,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0005,0,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,1,16'h0040,0,16'h0000, 0,16'h0000,0,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h2222, 0,16'h0000,0,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0040,0,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'hF000, 0,16'h0000,0,16'hA5A5,16'h0002,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,1,16'hF000,16'h0041,1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'hF000,16'h0041,1));
    tbl.push_back(mk(0,1,1,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'hF000,16'h0041,1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0041,1));
    tbl.push_back(mk(0,0,0,1,16'h0010,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0041,1));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0010,0,16'h0000,16'h0041,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h3333, 0,16'h0000,0,16'h0000,16'h0041,0));
    tbl.push_back(mk(0,0,0,1,16'hFFFF,0,16'h0000, 0,16'h0000,1,16'h3333,16'h0011,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'hFFFF,0,16'h3333,16'h0011,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h4444, 0,16'h0000,0,16'h3333,16'h0011,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0000,1,16'h4444,16'h0000,0));
    tbl.push_back(mk(0,1,0,0,16'h0000,1,16'h5555, 0,16'h0000,0,16'h4444,16'h0000,0));
    tbl.push_back(mk(0,1,1,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h4444,16'h0000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,1,16'h6666, 0,16'h0000,0,16'h0000,16'h0000,0));
    tbl.push_back(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0001,1,16'h6666,16'h0001,0));

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

    // reset while a request is in flight; the stale response lands in the first post-reset cycle
    run_row(mk(1,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h6666,16'h0001,0), "rst_mid0");
    run_row(mk(0,0,0,0,16'h0000,1,16'h7777, 1,16'h0000,0,16'h0000,16'h0000,0), "rst_mid1");
    run_row(mk(0,0,0,0,16'h0000,0,16'h0000, 0,16'h0000,0,16'h0000,16'h0000,0), "rst_mid2");
    run_row(mk(0,0,0,0,16'h0000,1,16'h8888, 0,16'h0000,0,16'h0000,16'h0000,0), "rst_mid3");
    run_row(mk(0,0,0,0,16'h0000,0,16'h0000, 1,16'h0001,1,16'h8888,16'h0001,0), "rst_mid4");

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem_busy = 1'b0;
    mem_left = 0;
    mem_addr = 16'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      r_rst   = (cyc < 2) || ($urandom_range(0, 199) == 0);
      r_redir = ($urandom_range(0, 19) == 0);
      r_rpc   = ($urandom_range(0, 7) == 0) ? (16'hFFFE + 16'($urandom_range(0, 1)))
                                            : 16'($urandom_range(0, 255));
      r_flush = ($urandom_range(0, 14) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_mv    = 1'b0;
      r_mrd   = 16'($urandom);
      if (r_rst) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_left--;
        if (mem_left == 0) begin
          mem_busy = 1'b0;
          r_mv     = 1'b1;
          r_mrd    = mem[mem_addr[7:0]];
        end
      end
      drive(r_rst, r_stall, r_flush, r_redir, r_rpc, r_mv, r_mrd);
      #1;
      e_req = !r_rst && !r_redir && !m_pend && !m_hold_v && !m_halted;
      if (cyc >= 2) begin
        check("rnd req", 16'(imem.imem_req), 16'(e_req));
        if (e_req) check("rnd addr", imem.imem_addr, m_pc);
        check("rnd ifid_valid", 16'(ifid_valid), 16'(m_iv));
        check("rnd ifid_instr", ifid_instr, m_ii);
        check("rnd ifid_pc", ifid_pc, m_ip);
        check("rnd halted", 16'(halted), 16'(m_halted));
`ifdef FETCH_PERF_CNT_EN
        check("rnd fetch_count", fetch_count, m_cnt);
`endif
      end
      if (imem.imem_req && !r_rst) begin
        mem_busy = 1'b1;
        mem_left = $urandom_range(1, 3);
        mem_addr = imem.imem_addr;
      end
      model_step(r_rst, r_redir, r_rpc, r_flush, r_stall, r_mv, r_mrd, e_req);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
